elevator_fsm: RTL and testbench

ELEVATOR_FSM -- requirements
Module: elevator_fsm

---
 rtl/elevator_fsm_pkg.sv | 37 +++
 rtl/elevator_fsm_if.sv | 27 ++
 rtl/elevator_fsm.sv | 80 ++++++++
 tb/tb_elevator_fsm.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_fsm_pkg.sv
// Shared state encoding and output decode for the elevator control FSM.
// Output decode is a pure function of state, so every user of it stays a Moore machine.
package elevator_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MOVE_UP   = 3'd1,
        MOVE_DOWN = 3'd2,
        DOOR_OPEN = 3'd3,
        POP       = 3'd4,
        ALARM     = 3'd5
    } state_t;

    typedef struct packed {
        logic move_up;
        logic move_down;
        logic fifo_rd_en;
        logic alarm;
        logic open_door;
    } outs_t;

    // Exactly one output per active state, so motor and door drive are mutually exclusive.
    function automatic outs_t decode_outputs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            MOVE_UP:   o.move_up    = 1'b1;
            MOVE_DOWN: o.move_down  = 1'b1;
            DOOR_OPEN: o.open_door  = 1'b1;
            POP:       o.fifo_rd_en = 1'b1;
            ALARM:     o.alarm      = 1'b1;
            default:   o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/elevator_fsm_if.sv
// Groups the comparator, fault, timer and actuator signals of the elevator FSM.
// The controller modport drives requests/status; the fsm modport drives actuator commands.
interface elevator_fsm_if;

    logic move_up_req;
    logic move_down_req;
    logic equal;
    logic error_flag;
    logic error_clear;
    logic counter_done;
    logic move_up;
    logic move_down;
    logic fifo_rd_en;
    logic alarm;
    logic open_door;

    modport master (
        output move_up_req, move_down_req, equal, error_flag, error_clear, counter_done,
        input  move_up, move_down, fifo_rd_en, alarm, open_door
    );

    modport slave (
        input  move_up_req, move_down_req, equal, error_flag, error_clear, counter_done,
        output move_up, move_down, fifo_rd_en, alarm, open_door
    );

endinterface

// File: rtl/elevator_fsm.sv
// Elevator motion/door/fault controller: Moore FSM, outputs follow inputs one edge later.
// No backpressure: fifo_rd_en is a single-cycle pop per served request.
module elevator_fsm
    import elevator_fsm_pkg::*;
(
    input  logic i_fsm_clock,
    input  logic i_fsm_reset,
    input  logic i_ctrl_fsm_move_up,
    input  logic i_ctrl_fsm_move_down,
    input  logic i_ctrl_fsm_equal,
    input  logic i_fsm_error_flag,
    input  logic i_fsm_error_clear,
    input  logic i_counter_fsm_done,
    output logic o_fsm_move_up,
    output logic o_fsm_move_down,
    output logic o_fsm_fifo_rd_en,
    output logic o_fsm_alarm,
    output logic o_fsm_open_door
);

    state_t state;
    state_t state_nxt;
    outs_t  outs;

    always_ff @(posedge i_fsm_clock or negedge i_fsm_reset) begin
        if (!i_fsm_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (i_ctrl_fsm_equal)          state_nxt = DOOR_OPEN;
                else if (i_ctrl_fsm_move_up)   state_nxt = MOVE_UP;
                else if (i_ctrl_fsm_move_down) state_nxt = MOVE_DOWN;
                else                           state_nxt = IDLE;
            end
            MOVE_UP: begin
                if (i_ctrl_fsm_equal)         state_nxt = DOOR_OPEN;
                else if (!i_ctrl_fsm_move_up) state_nxt = IDLE;
                else                          state_nxt = MOVE_UP;
            end
            MOVE_DOWN: begin
                if (i_ctrl_fsm_equal)           state_nxt = DOOR_OPEN;
                else if (!i_ctrl_fsm_move_down) state_nxt = IDLE;
                else                            state_nxt = MOVE_DOWN;
            end
            DOOR_OPEN: begin
                state_nxt = i_counter_fsm_done ? POP : DOOR_OPEN;
            end
            POP: begin
                state_nxt = IDLE;
            end
            ALARM: begin
                // An acknowledge only counts once the fault itself has gone away.
                if (i_fsm_error_clear && !i_fsm_error_flag) state_nxt = IDLE;
                else                                        state_nxt = ALARM;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (i_fsm_error_flag && (state != ALARM)) begin
            state_nxt = ALARM;
        end
    end

    assign outs             = decode_outputs(state);
    assign o_fsm_move_up    = outs.move_up;
    assign o_fsm_move_down  = outs.move_down;
    assign o_fsm_fifo_rd_en = outs.fifo_rd_en;
    assign o_fsm_alarm      = outs.alarm;
    assign o_fsm_open_door  = outs.open_door;

endmodule

// File: tb/tb_elevator_fsm.sv
// Directed-vector bench for elevator_fsm; outputs checked as {up, down, rd_en, alarm, door}.
module tb_elevator_fsm;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    elevator_fsm_if u_if ();

    elevator_fsm u_dut (
        .i_fsm_clock          (clk),
        .i_fsm_reset          (rst_n),
        .i_ctrl_fsm_move_up   (u_if.move_up_req),
        .i_ctrl_fsm_move_down (u_if.move_down_req),
        .i_ctrl_fsm_equal     (u_if.equal),
        .i_fsm_error_flag     (u_if.error_flag),
        .i_fsm_error_clear    (u_if.error_clear),
        .i_counter_fsm_done   (u_if.counter_done),
        .o_fsm_move_up        (u_if.move_up),
        .o_fsm_move_down      (u_if.move_down),
        .o_fsm_fifo_rd_en     (u_if.fifo_rd_en),
        .o_fsm_alarm          (u_if.alarm),
        .o_fsm_open_door      (u_if.open_door)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_UP    = 5'b10000;
    localparam logic [4:0] O_DOWN  = 5'b01000;
    localparam logic [4:0] O_POP   = 5'b00100;
    localparam logic [4:0] O_ALARM = 5'b00010;
    localparam logic [4:0] O_DOOR  = 5'b00001;

    function automatic logic [4:0] outs();
        return {u_if.move_up, u_if.move_down, u_if.fifo_rd_en, u_if.alarm, u_if.open_door};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic up, input logic dn, input logic eq,
                         input logic flag, input logic clr, input logic done);
        u_if.move_up_req   = up;
        u_if.move_down_req = dn;
        u_if.equal         = eq;
        u_if.error_flag    = flag;
        u_if.error_clear   = clr;
        u_if.counter_done  = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL reset_async: got %b want %b", outs(), O_NONE);
        end
        // Inputs asking for motion must be ignored while reset is held.
        drive(1, 0, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL reset_held: got %b want %b", outs(), O_NONE);
        end
        rst_n = 1'b1;
        step();
        vecs++;
        if (outs() !== O_UP) begin
            errs++; $display("FAIL reset_release_up: got %b want %b", outs(), O_UP);
        end
    endtask

    task automatic test_error_in_motion();
        drive(1, 0, 0, 1, 0, 0);
        step();
        vecs++;
        if (outs() !== O_ALARM) begin
            errs++; $display("FAIL err_to_alarm: got %b want %b", outs(), O_ALARM);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vecs++;
            if (outs() !== O_ALARM) begin
                errs++; $display("FAIL err_alarm_hold[%0d]: got %b want %b", i, outs(), O_ALARM);
            end
        end
        drive(1, 0, 0, 0, 1, 0);
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL alarm_clear_idle: got %b want %b", outs(), O_NONE);
        end
        drive(1, 0, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_UP) begin
            errs++; $display("FAIL clear_resume_up: got %b want %b", outs(), O_UP);
        end
    endtask

    task automatic test_door_cycle();
        drive(1, 0, 1, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_DOOR) begin
            errs++; $display("FAIL up_arrive_door: got %b want %b", outs(), O_DOOR);
        end
        // Comparator inputs are don't-care while the door is open.
        drive(1, 1, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_DOOR) begin
            errs++; $display("FAIL door_hold: got %b want %b", outs(), O_DOOR);
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        vecs++;
        if (outs() !== O_POP) begin
            errs++; $display("FAIL door_pop: got %b want %b", outs(), O_POP);
        end
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL pop_one_cycle: got %b want %b", outs(), O_NONE);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL idle_after_pop: got %b want %b", outs(), O_NONE);
        end
    endtask

    task automatic test_alarm_clear_held();
        drive(0, 0, 0, 1, 0, 0);
        step();
        vecs++;
        if (outs() !== O_ALARM) begin
            errs++; $display("FAIL idle_err_alarm: got %b want %b", outs(), O_ALARM);
        end
        drive(0, 0, 0, 1, 1, 0);
        step();
        vecs++;
        if (outs() !== O_ALARM) begin
            errs++; $display("FAIL clear_with_flag: got %b want %b", outs(), O_ALARM);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_ALARM) begin
            errs++; $display("FAIL flag_drop_no_clear: got %b want %b", outs(), O_ALARM);
        end
        drive(0, 0, 0, 0, 1, 0);
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL alarm_cleared: got %b want %b", outs(), O_NONE);
        end
        // Acknowledge outside ALARM has no effect.
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL clear_in_idle: got %b want %b", outs(), O_NONE);
        end
    endtask

    task automatic test_priority();
        drive(1, 1, 1, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_DOOR) begin
            errs++; $display("FAIL prio_equal: got %b want %b", outs(), O_DOOR);
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_UP) begin
            errs++; $display("FAIL prio_up_over_down: got %b want %b", outs(), O_UP);
        end
        drive(0, 1, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL up_drop_idle: got %b want %b", outs(), O_NONE);
        end
    endtask

    task automatic test_move_down();
        drive(0, 1, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_DOWN) begin
            errs++; $display("FAIL idle_down: got %b want %b", outs(), O_DOWN);
        end
        step();
        vecs++;
        if (outs() !== O_DOWN) begin
            errs++; $display("FAIL down_hold: got %b want %b", outs(), O_DOWN);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL down_drop_idle: got %b want %b", outs(), O_NONE);
        end
        drive(0, 1, 0, 0, 0, 0);
        step();
        drive(0, 1, 1, 0, 0, 0);
        step();
        vecs++;
        if (outs() !== O_DOOR) begin
            errs++; $display("FAIL down_arrive_door: got %b want %b", outs(), O_DOOR);
        end
    endtask

    task automatic test_reset_in_door();
        // Enters from DOOR_OPEN left by test_move_down.
        drive(0, 0, 0, 0, 0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL reset_door_async: got %b want %b", outs(), O_NONE);
        end
        step();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL no_pop_after_reset: got %b want %b", outs(), O_NONE);
        end
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL idle_after_reset: got %b want %b", outs(), O_NONE);
        end
    endtask

    task automatic test_reset_in_alarm();
        drive(0, 0, 0, 1, 0, 0);
        step();
        vecs++;
        if (outs() !== O_ALARM) begin
            errs++; $display("FAIL pre_reset_alarm: got %b want %b", outs(), O_ALARM);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL reset_alarm_async: got %b want %b", outs(), O_NONE);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        vecs++;
        if (outs() !== O_NONE) begin
            errs++; $display("FAIL alarm_gone_after_reset: got %b want %b", outs(), O_NONE);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_error_in_motion();
        test_door_cycle();
        test_alarm_clear_held();
        test_priority();
        test_move_down();
        test_reset_in_door();
        test_reset_in_alarm();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
